// File: rtl/tft_init_sequencer.sv
// rtl/tft_init_sequencer.sv - TFT panel reset/init sequencer and RGB565 frame streamer
// Sole writer of the 9-bit {dc, byte} serializer word and its one-cycle load strobe.
module tft_init_sequencer #(
   parameter int RESET_CYCLES = 1000,
   parameter int DELAY_UNIT   = 1000
) (
   input  logic        spiClk,
   input  logic        resetN,
   output logic        tft_rst_n,
   output logic [8:0]  spi_data,
   output logic        spi_dataAvailable,
   input  logic        spi_idle,
   input  logic        frame_start,
   input  logic [15:0] pix_data,
   input  logic        pix_valid,
   input  logic        pix_last,
   output logic        pix_ready,
   output logic        init_done,
   output logic        busy
);

   localparam int DELAY_MAX = 255 * DELAY_UNIT;
   localparam int COUNT_MAX = (DELAY_MAX > RESET_CYCLES) ? DELAY_MAX : RESET_CYCLES;
   localparam int CW        = $clog2(COUNT_MAX + 1);

   localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] UNIT     = CW'(DELAY_UNIT);

   localparam logic [3:0] S_HW_RST    = 4'd0;
   localparam logic [3:0] S_RST_WAIT  = 4'd1;
   localparam logic [3:0] S_FETCH     = 4'd2;
   localparam logic [3:0] S_SEND      = 4'd3;
   localparam logic [3:0] S_WAIT_BUSY = 4'd4;
   localparam logic [3:0] S_WAIT_DONE = 4'd5;
   localparam logic [3:0] S_DELAY     = 4'd6;
   localparam logic [3:0] S_READY     = 4'd7;
   localparam logic [3:0] S_PIX_WAIT  = 4'd8;

   localparam logic [1:0] OP_DELAY = 2'b10;
   localparam logic [1:0] OP_END   = 2'b11;

   // Frame steps: which word of the frame just finished on the wire.
   localparam logic [1:0] STEP_CMD = 2'd0;
   localparam logic [1:0] STEP_HI  = 2'd1;

   logic [3:0]    state;
   logic [CW-1:0] cnt;
   logic [3:0]    idx;
   logic [8:0]    word;
   logic          in_frame;
   logic [1:0]    step;
   logic [7:0]    pix_lo;
   logic          last;
   logic [9:0]    entry;

   function automatic logic [9:0] table_entry(input logic [3:0] i);
      case (i)
         4'd0:    table_entry = {2'b00, 8'h01};
         4'd1:    table_entry = {2'b10, 8'd150};
         4'd2:    table_entry = {2'b00, 8'h11};
         4'd3:    table_entry = {2'b10, 8'd120};
         4'd4:    table_entry = {2'b00, 8'h3A};
         4'd5:    table_entry = {2'b01, 8'h55};
         4'd6:    table_entry = {2'b00, 8'h36};
         4'd7:    table_entry = {2'b01, 8'h48};
         4'd8:    table_entry = {2'b00, 8'h29};
         default: table_entry = {2'b11, 8'h00};
      endcase
   endfunction

   always_comb begin
      entry = table_entry(idx);
   end

   always_ff @(posedge spiClk) begin
      if (!resetN) begin
         state     <= S_HW_RST;
         cnt       <= '0;
         idx       <= '0;
         word      <= '0;
         in_frame  <= 1'b0;
         step      <= STEP_CMD;
         pix_lo    <= '0;
         last      <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            S_HW_RST: begin
               if (cnt == RST_LAST) begin
                  cnt   <= '0;
                  state <= S_RST_WAIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RST_WAIT: begin
               if (cnt == RST_LAST) begin
                  cnt   <= '0;
                  state <= S_FETCH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_FETCH: begin
               case (entry[9:8])
                  OP_DELAY: begin
                     cnt   <= CW'(entry[7:0]) * UNIT;
                     state <= S_DELAY;
                  end
                  OP_END: begin
                     init_done <= 1'b1;
                     state     <= S_READY;
                  end
                  default: begin
                     // op[0] doubles as dc: 00 = command, 01 = data.
                     word     <= {entry[8], entry[7:0]};
                     in_frame <= 1'b0;
                     state    <= S_SEND;
                  end
               endcase
            end
            S_SEND: begin
               if (spi_idle) state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (!spi_idle) state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (spi_idle) begin
                  if (!in_frame) begin
                     idx   <= idx + 1'b1;
                     state <= S_FETCH;
                  end else if (step == STEP_CMD) begin
                     state <= S_PIX_WAIT;
                  end else if (step == STEP_HI) begin
                     word  <= {1'b1, pix_lo};
                     step  <= 2'd2;
                     state <= S_SEND;
                  end else begin
                     state <= last ? S_READY : S_PIX_WAIT;
                  end
               end
            end
            S_DELAY: begin
               if (cnt == '0) begin
                  idx   <= idx + 1'b1;
                  state <= S_FETCH;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_READY: begin
               if (frame_start) begin
                  word     <= 9'h02C;
                  in_frame <= 1'b1;
                  step     <= STEP_CMD;
                  state    <= S_SEND;
               end
            end
            S_PIX_WAIT: begin
               if (pix_valid) begin
                  word   <= {1'b1, pix_data[15:8]};
                  pix_lo <= pix_data[7:0];
                  last   <= pix_last;
                  step   <= STEP_HI;
                  state  <= S_SEND;
               end
            end
            default: state <= S_HW_RST;
         endcase
      end
   end

   // Strobe is gated by idle directly so it can never fire into a busy serializer.
   assign spi_dataAvailable = (state == S_SEND) && spi_idle;
   assign spi_data          = word;
   assign tft_rst_n         = (state != S_HW_RST);
   assign pix_ready         = (state == S_PIX_WAIT);
   assign busy              = (state != S_READY);

endmodule

// File: tb/tb_tft_init_sequencer.sv
// tb/tb_tft_init_sequencer.sv - self-checking bench for tft_init_sequencer
module tb_tft_init_sequencer;
   localparam int RC = 4;
   localparam int DU = 2;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        tft_rst_n;
   logic [8:0]  spi_data;
   logic        spi_dataAvailable;
   logic        spi_idle;
   logic        frame_start = 1'b0;
   logic [15:0] pix_data = 16'h0;
   logic        pix_valid = 1'b0;
   logic        pix_last = 1'b0;
   logic        pix_ready;
   logic        init_done;
   logic        busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tft_init_sequencer #(.RESET_CYCLES(RC), .DELAY_UNIT(DU)) dut (
      .spiClk(clk), .resetN(resetN), .tft_rst_n(tft_rst_n), .spi_data(spi_data),
      .spi_dataAvailable(spi_dataAvailable), .spi_idle(spi_idle), .frame_start(frame_start),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
      .init_done(init_done), .busy(busy)
   );

   // Serializer model: idle drops the cycle after a strobe and stays low busy_len cycles.
   int busy_len = 40;
   int busy_cnt = 0;
   always @(posedge clk) begin
      if (spi_dataAvailable) busy_cnt <= busy_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign spi_idle = (busy_cnt == 0);

   int         cyc = 0;
   logic       prev_strobe = 1'b0;
   logic       prev_done = 1'b0;
   int         viol_idle = 0;
   int         viol_b2b = 0;
   int         viol_done = 0;
   logic [8:0] got_q[$];
   int         stamp_q[$];

   always @(negedge clk) begin
      cyc++;
      if (spi_dataAvailable) begin
         got_q.push_back(spi_data);
         stamp_q.push_back(cyc);
         if (!spi_idle) viol_idle++;
         if (prev_strobe) viol_b2b++;
      end
      prev_strobe = spi_dataAvailable;
      if (init_done && !prev_done && busy) viol_done++;
      prev_done = init_done;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      checks++;
      if (got < lo || got > hi) begin
         failures++;
         $display("FAIL %s got=%0d expected in [%0d,%0d]", name, got, lo, hi);
      end
   endtask

   task automatic compare_q(input string name, input logic [8:0] exp[$]);
      check({name, "_count"}, got_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got_q.size(); i++)
         check($sformatf("%s[%0d]", name, i), 32'(got_q[i]), 32'(exp[i]));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tft_rst_n"}, 32'(tft_rst_n), 0);
      check({tag, "_strobe"}, 32'(spi_dataAvailable), 0);
      check({tag, "_spi_data"}, 32'(spi_data), 0);
      check({tag, "_pix_ready"}, 32'(pix_ready), 0);
      check({tag, "_init_done"}, 32'(init_done), 0);
      check({tag, "_busy"}, 32'(busy), 1);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (busy && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 32'(busy), 0);
   endtask

   task automatic pulse_frame_start();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic send_pixel(input logic [15:0] p, input logic l, input int stall);
      int n = 0;
      pix_valid = 1'b0;
      repeat (stall) @(negedge clk);
      pix_data = p;
      pix_last = l;
      pix_valid = 1'b1;
      while (!pix_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("pix_handshake", 32'(pix_ready), 1);
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   typedef struct {
      logic [15:0] p0;
      logic [15:0] p1;
      int          stall;
      int          blen;
      logic [44:0] words;
   } vec_t;

   vec_t       vecs[4];
   logic [8:0] init_words[$];
   logic [8:0] exp_q[$];

   initial begin
      int low_cnt;
      int first_idx;
      int n;
      int n0;
      int rel;
      logic [44:0] tmp;

      init_words = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};
      vecs[0] = '{16'hF800, 16'h07E0, 0, 40, {9'h02C, 9'h1F8, 9'h100, 9'h107, 9'h1E0}};
      vecs[1] = '{16'h001F, 16'hFFFF, 20, 8, {9'h02C, 9'h100, 9'h11F, 9'h1FF, 9'h1FF}};
      vecs[2] = '{16'h1234, 16'hABCD, 3, 2, {9'h02C, 9'h112, 9'h134, 9'h1AB, 9'h1CD}};
      vecs[3] = '{16'h0000, 16'h8001, 0, 1, {9'h02C, 9'h100, 9'h100, 9'h180, 9'h101}};

      // Reset state and release timing
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      got_q.delete();
      stamp_q.delete();
      resetN = 1'b1;
      low_cnt = 0;
      first_idx = -1;
      for (int i = 0; i < 3000 && first_idx < 0; i++) begin
         if (!tft_rst_n) low_cnt++;
         if (spi_dataAvailable) begin
            first_idx = i;
            check("first_word", 32'(spi_data), 32'h001);
         end
         if (first_idx < 0) @(negedge clk);
      end
      check("rst_low_cycles", low_cnt, RC);
      check_range("first_strobe_cycle", first_idx, 2 * RC, 2 * RC + 4);

      // frame_start during init must be ignored
      repeat (20) @(negedge clk);
      pulse_frame_start();
      wait_ready("init");
      check("init_done", 32'(init_done), 1);
      @(negedge clk);
      compare_q("init_seq", init_words);
      if (stamp_q.size() >= 3) begin
         check_range("gap_after_001", stamp_q[1] - stamp_q[0], 150 * DU, 150 * DU + busy_len + 20);
         check_range("gap_after_011", stamp_q[2] - stamp_q[1], 120 * DU, 120 * DU + busy_len + 20);
      end

      // Directed frames from the vector table
      foreach (vecs[v]) begin
         busy_len = vecs[v].blen;
         got_q.delete();
         pulse_frame_start();
         check("busy_in_frame", 32'(busy), 1);
         send_pixel(vecs[v].p0, 1'b0, 0);
         n = 0;
         while (!pix_ready && n < 5000) begin
            @(negedge clk);
            n++;
         end
         check("pix_wait_reentry", 32'(pix_ready), 1);
         n0 = got_q.size();
         repeat (vecs[v].stall) @(negedge clk);
         check("stall_no_strobe", got_q.size() - n0, 0);
         send_pixel(vecs[v].p1, 1'b1, 0);
         wait_ready($sformatf("vec%0d", v));
         @(negedge clk);
         exp_q.delete();
         for (int i = 0; i < 5; i++) begin
            tmp = vecs[v].words >> (9 * (4 - i));
            exp_q.push_back(tmp[8:0]);
         end
         compare_q($sformatf("vec%0d", v), exp_q);
      end

      // Randomized frames against a word-list model
      for (int f = 0; f < 8; f++) begin
         int len;
         logic [15:0] p;
         len = $urandom_range(1, 4);
         busy_len = $urandom_range(1, 12);
         got_q.delete();
         exp_q.delete();
         exp_q.push_back(9'h02C);
         pulse_frame_start();
         for (int k = 0; k < len; k++) begin
            p = 16'($urandom);
            exp_q.push_back({1'b1, p[15:8]});
            exp_q.push_back({1'b1, p[7:0]});
            if ($urandom_range(0, 3) == 0) pulse_frame_start();
            send_pixel(p, (k == len - 1), $urandom_range(0, 5));
         end
         wait_ready($sformatf("rand%0d", f));
         @(negedge clk);
         compare_q($sformatf("rand%0d", f), exp_q);
      end

      // Reset during the delay after cmd 11
      busy_len = 40;
      resetN = 1'b0;
      @(negedge clk);
      got_q.delete();
      resetN = 1'b1;
      n = 0;
      while (got_q.size() < 2 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("reached_011", got_q.size(), 2);
      repeat (60) @(negedge clk);
      resetN = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_in_delay");
      got_q.delete();
      resetN = 1'b1;
      wait_ready("reinit1");
      @(negedge clk);
      compare_q("reinit1_seq", init_words);

      // Reset while the 1F8 byte is on the wire
      got_q.delete();
      pulse_frame_start();
      pix_data = 16'hF800;
      pix_last = 1'b0;
      pix_valid = 1'b1;
      n = 0;
      while (got_q.size() < 2 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("reached_1F8", got_q.size(), 2);
      if (got_q.size() >= 2) check("word_1F8", 32'(got_q[1]), 32'h1F8);
      resetN = 1'b0;
      pix_valid = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_in_frame");
      got_q.delete();
      stamp_q.delete();
      resetN = 1'b1;
      rel = cyc;
      wait_ready("reinit2");
      @(negedge clk);
      compare_q("reinit2_seq", init_words);
      if (stamp_q.size() > 0) check_range("first_after_busy", stamp_q[0] - rel, 30, 100);

      check("no_strobe_while_busy", viol_idle, 0);
      check("no_back_to_back", viol_b2b, 0);
      check("done_with_busy_fall", viol_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/tft_init_sequencer.md
Name: tft_init_sequencer

Overview:
- Controller that drives the 9-bit TFT SPI serializer (the {dc, byte} word and one-cycle load strobe).
- After reset it pulses the panel hardware reset and then plays a fixed init command table with programmed delays.
- When init is complete, it accepts frames: it issues the memory-write command 0x2C, then streams 16-bit RGB565 pixels as two data bytes each, MSB first.
- It is the only writer of the serializer's input.

Parameters:
- RESET_CYCLES, 1000, spiClk cycles that tft_rst_n is held low, and also the wait after release.
- DELAY_UNIT, 1000, spiClk cycles per delay tick in a table delay entry.

Ports:
- spiClk  in  1  clock shared with the serializer.
- resetN  in  1  synchronous active-low reset.
- tft_rst_n  out  1  panel hardware reset, active low.
- spi_data  out  9  serializer word: bit 8 = dc, bits 7:0 = byte.
- spi_dataAvailable  out  1  one-cycle load strobe to the serializer.
- spi_idle  in  1  serializer idle flag.
- frame_start  in  1  pulse requesting a new frame; honoured only in READY.
- pix_data  in  16  RGB565 pixel.
- pix_valid  in  1  pixel valid.
- pix_last  in  1  qualifies the final pixel of a frame.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
- init_done  out  1  high from the end of the table onward.
- busy  out  1  high in every state except READY.

Behaviour:
- Reset (resetN = 0 at a spiClk edge):
  - state = HW_RST; all counters = 0; table index = 0.
  - tft_rst_n = 0, spi_dataAvailable = 0, spi_data = 0, pix_ready = 0, init_done = 0, busy = 1.
  - Reset mid-transfer abandons the word. The serializer finishes it on its own; the controller's send handshake waits on spi_idle, so the next word cannot collide with it.
- Table entries are 10 bits, {op[1:0], val[7:0]}:
  - op 00: command, dc = 0.
  - op 01: data, dc = 1.
  - op 10: delay of val*DELAY_UNIT cycles; val = 0 means zero wait.
  - op 11: end of table.
- Table contents, in order:
  - cmd 01, delay 150
  - cmd 11, delay 120
  - cmd 3A, data 55
  - cmd 36, data 48
  - cmd 29, end
- State machine:
  - HW_RST: tft_rst_n = 0 for RESET_CYCLES cycles -> RST_WAIT.
  - RST_WAIT: tft_rst_n = 1, wait RESET_CYCLES cycles -> FETCH.
  - FETCH: decode the entry at the index.
    - cmd/data -> SEND with the word latched.
    - delay -> DELAY with counter = val*DELAY_UNIT.
    - end -> READY, and set init_done.
  - SEND: wait until spi_idle = 1, then assert spi_dataAvailable for exactly 1 cycle with spi_data stable -> WAIT_BUSY.
  - WAIT_BUSY: wait for spi_idle = 0. The serializer drops idle the cycle after the strobe. The strobe is never reasserted here.
  - WAIT_BUSY -> WAIT_DONE when spi_idle = 0.
  - WAIT_DONE: wait for spi_idle = 1, then return to the caller context:
    - init: index + 1 -> FETCH.
    - frame: next step (see below).
  - DELAY: decrement the counter; at 0, index + 1 -> FETCH.
  - READY: busy = 0. frame_start = 1 -> send word {0, 0x2C} -> PIX_WAIT.
  - PIX_WAIT: pix_ready = 1 for one cycle at a time. On a handshake:
    - latch the pixel and the last flag; pix_ready drops the next cycle;
    - send {1, pix[15:8]} then {1, pix[7:0]};
    - if last -> READY, else -> PIX_WAIT.
- Handshake and ordering rules:
  - spi_dataAvailable is never high in two consecutive cycles.
  - spi_dataAvailable is never high while spi_idle = 0.
  - Minimum spacing between strobes is one full serializer word.
- Frame edge cases:
  - frame_start outside READY is ignored; it is not queued.
  - pix_valid with no pix_ready is held by upstream (standard valid/ready). Data must not change while valid and not ready.
  - A pixel with pix_last = 1 ends the frame after its low byte completes.
- Delay arithmetic: counter width holds 255*DELAY_UNIT. The product is computed at parameter elaboration, not at run time.

Test Plan:
- Reset release with RESET_CYCLES = 4, DELAY_UNIT = 2 -> tft_rst_n low for exactly 4 cycles, then high. The first strobe carries spi_data = 0x001 no earlier than cycle 8 after release.
- Full init, with the real serializer connected -> strobed words in order 001, 011, 03A, 155, 036, 148, 029. Gaps of 300 and 240 cycles (plus idle wait) follow 001 and 011. init_done rises after 029 completes; busy falls the same cycle.
- Serializer model holds idle low for 40 cycles per word -> no strobe while idle = 0. Exactly 7 strobes in total during init.
- Frame: frame_start, then pixels F800 and 07E0 with last on the second -> words 02C, 1F8, 100, 107, 1E0. Then READY, busy = 0.
- Upstream stalls pix_valid low for 20 cycles mid-frame -> no strobes during the stall. The byte sequence is unchanged afterwards.
- resetN low during the DELAY after cmd 11, and again during the byte 1F8 of a frame -> outputs return to reset values next edge. The sequence restarts from HW_RST. The first new strobe waits for spi_idle = 1.
